// File: rtl/execute_stage_if.sv
// Decoder-to-execute bundle and execute-stage outputs (write port, jump redirect, flush).
// No backpressure: the stage accepts a bundle every cycle; out_flush tells upstream to squash.
interface execute_stage_if #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int PC_WIDTH        = 12,
    parameter int CNT_WIDTH       = 16
);
    logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx;
    logic [IALU_WORD_WIDTH-1:0] in_src1;
    logic [IALU_WORD_WIDTH-1:0] in_src2;
    logic                       in_act_ialu_add;
    logic                       in_act_incr_pc_is_res;
    logic                       in_act_jump_to_ialu_res;
    logic                       in_act_write_res_to_reg;
    logic [PC_WIDTH-1:0]        in_pc;

    logic [IALU_WORD_WIDTH-1:0] out_ialu_res;
    logic                       out_wr_en;
    logic [REG_IDX_WIDTH-1:0]   out_wr_idx;
    logic [IALU_WORD_WIDTH-1:0] out_wr_data;
    logic                       out_jump;
    logic [PC_WIDTH-1:0]        out_jump_target;
    logic                       out_flush;
    logic [CNT_WIDTH-1:0]       out_jump_count;

    modport master (
        output in_res_reg_idx, in_src1, in_src2, in_act_ialu_add, in_act_incr_pc_is_res,
               in_act_jump_to_ialu_res, in_act_write_res_to_reg, in_pc,
        input  out_ialu_res, out_wr_en, out_wr_idx, out_wr_data, out_jump,
               out_jump_target, out_flush, out_jump_count
    );

    modport slave (
        input  in_res_reg_idx, in_src1, in_src2, in_act_ialu_add, in_act_incr_pc_is_res,
               in_act_jump_to_ialu_res, in_act_write_res_to_reg, in_pc,
        output out_ialu_res, out_wr_en, out_wr_idx, out_wr_data, out_jump,
               out_jump_target, out_flush, out_jump_count
    );
endinterface

// File: rtl/execute_stage.sv
// Integer execute stage: registers the decoded bundle, adds, forms link value,
// drives the register write port and jump redirect, and flushes the wrong path.
module execute_stage #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int PC_WIDTH        = 12,
    parameter int FLUSH_CYCLES    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input logic            clock,
    input logic            reset,
    execute_stage_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [REG_IDX_WIDTH-1:0]   res_reg_idx_q;
    logic [IALU_WORD_WIDTH-1:0] src1_q;
    logic [IALU_WORD_WIDTH-1:0] src2_q;
    logic [PC_WIDTH-1:0]        pc_q;
    logic                       act_ialu_add_q;
    logic                       act_incr_pc_is_res_q;
    logic                       act_jump_to_ialu_res_q;
    logic                       act_write_res_to_reg_q;
    logic [FC_W-1:0]            flush_cnt;
    logic [CNT_WIDTH-1:0]       jump_count;

    logic [IALU_WORD_WIDTH-1:0] ialu_res;
    logic [PC_WIDTH-1:0]        pc_plus_one;
    logic [IALU_WORD_WIDTH-1:0] link_value;
    logic                       jump;
    logic                       flush;

    always_comb begin
        ialu_res    = act_ialu_add_q ? (src1_q + src2_q) : '0;
        pc_plus_one = pc_q + 1'b1;
        link_value  = IALU_WORD_WIDTH'(pc_plus_one);
        jump        = act_jump_to_ialu_res_q;
        flush       = jump | (flush_cnt != '0);
    end

    // Operands, index and pc always load; only the actions are squashed on flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_reg_idx_q          <= '0;
            src1_q                 <= '0;
            src2_q                 <= '0;
            pc_q                   <= '0;
            act_ialu_add_q         <= 1'b0;
            act_incr_pc_is_res_q   <= 1'b0;
            act_jump_to_ialu_res_q <= 1'b0;
            act_write_res_to_reg_q <= 1'b0;
        end else begin
            res_reg_idx_q          <= bus.in_res_reg_idx;
            src1_q                 <= bus.in_src1;
            src2_q                 <= bus.in_src2;
            pc_q                   <= bus.in_pc;
            act_ialu_add_q         <= bus.in_act_ialu_add & ~flush;
            act_incr_pc_is_res_q   <= bus.in_act_incr_pc_is_res & ~flush;
            act_jump_to_ialu_res_q <= bus.in_act_jump_to_ialu_res & ~flush;
            act_write_res_to_reg_q <= bus.in_act_write_res_to_reg & ~flush;
        end
    end

    // The jump cycle itself is the first flush cycle, so the counter covers the rest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_cnt  <= '0;
            jump_count <= '0;
        end else begin
            if (jump) begin
                flush_cnt  <= FC_W'(FLUSH_CYCLES - 1);
                jump_count <= jump_count + 1'b1;
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_ialu_res    = ialu_res;
        bus.out_wr_en       = act_write_res_to_reg_q;
        bus.out_wr_idx      = res_reg_idx_q;
        bus.out_wr_data     = act_incr_pc_is_res_q ? link_value : ialu_res;
        bus.out_jump        = jump;
        bus.out_jump_target = ialu_res[PC_WIDTH-1:0];
        bus.out_flush       = flush;
        bus.out_jump_count  = jump_count;
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors checked one cycle after sampling.
module tb_execute_stage;
    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    execute_stage_if #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4), .PC_WIDTH(12), .CNT_WIDTH(16)) bus ();

    execute_stage #(
        .IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4), .PC_WIDTH(12), .FLUSH_CYCLES(2), .CNT_WIDTH(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic wr_en,
                              input logic [3:0] wr_idx, input logic [15:0] wr_data,
                              input logic jump, input logic [11:0] target,
                              input logic flush, input logic [15:0] cnt);
        check({tag, ".ialu_res"}, 32'(bus.out_ialu_res), 32'(res));
        check({tag, ".wr_en"}, 32'(bus.out_wr_en), 32'(wr_en));
        check({tag, ".wr_idx"}, 32'(bus.out_wr_idx), 32'(wr_idx));
        check({tag, ".wr_data"}, 32'(bus.out_wr_data), 32'(wr_data));
        check({tag, ".jump"}, 32'(bus.out_jump), 32'(jump));
        check({tag, ".target"}, 32'(bus.out_jump_target), 32'(target));
        check({tag, ".flush"}, 32'(bus.out_flush), 32'(flush));
        check({tag, ".jump_count"}, 32'(bus.out_jump_count), 32'(cnt));
    endtask

    task automatic bundle(input logic [3:0] idx, input logic [15:0] s1, input logic [15:0] s2,
                          input logic add, input logic link, input logic jmp, input logic wr,
                          input logic [11:0] pc);
        bus.in_res_reg_idx          = idx;
        bus.in_src1                 = s1;
        bus.in_src2                 = s2;
        bus.in_act_ialu_add         = add;
        bus.in_act_incr_pc_is_res   = link;
        bus.in_act_jump_to_ialu_res = jmp;
        bus.in_act_write_res_to_reg = wr;
        bus.in_pc                   = pc;
    endtask

    task automatic idle();
        bundle(4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    endtask

    // Outputs are checked 1 time unit after the edge that sampled the bundle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        idle();
        #1;
        expect_out("reset", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 0, 16'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Jump by immediate; count rises at the end of the jump cycle.
        bundle(4'd0, 16'h0010, 16'h0020, 1, 0, 1, 0, 12'h000);
        step(); expect_out("jmp_imm", 16'h0030, 0, 4'd0, 16'h0030, 1, 12'h030, 1, 16'd0);
        idle();
        step(); expect_out("jmp_imm_f1", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 1, 16'd1);
        step(); expect_out("jmp_imm_f2", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 0, 16'd1);

        // Jump-and-link.
        bundle(4'd3, 16'h0010, 16'h0005, 1, 1, 1, 1, 12'h011);
        step(); expect_out("jal", 16'h0015, 1, 4'd3, 16'h0012, 1, 12'h015, 1, 16'd1);
        idle();
        step(); step();
        check("jal_count", 32'(bus.out_jump_count), 32'd2);

        // Flush window: both bundles sampled while flush is high are squashed.
        bundle(4'd0, 16'h0040, 16'h0002, 1, 0, 1, 0, 12'h000);
        step(); expect_out("fw_jump", 16'h0042, 0, 4'd0, 16'h0042, 1, 12'h042, 1, 16'd2);
        bundle(4'd5, 16'h0001, 16'h0001, 1, 0, 0, 1, 12'h000);
        step(); expect_out("fw_sq1", 16'h0, 0, 4'd5, 16'h0, 0, 12'h0, 1, 16'd3);
        step(); expect_out("fw_sq2", 16'h0, 0, 4'd5, 16'h0, 0, 12'h0, 0, 16'd3);
        step(); expect_out("fw_write", 16'h0002, 1, 4'd5, 16'h0002, 0, 12'h002, 0, 16'd3);
        idle();
        step();

        // Carry and upper-bit wrap.
        bundle(4'd0, 16'hFFFF, 16'h0002, 1, 0, 1, 0, 12'h000);
        step(); expect_out("wrap_carry", 16'h0001, 0, 4'd0, 16'h0001, 1, 12'h001, 1, 16'd3);
        idle();
        step(); step();
        bundle(4'd0, 16'h0FFF, 16'h0001, 1, 0, 1, 0, 12'h000);
        step(); expect_out("wrap_target", 16'h1000, 0, 4'd0, 16'h1000, 1, 12'h000, 1, 16'd4);
        idle();
        step(); step();

        // Link values, including pc wrap.
        bundle(4'd4, 16'h0000, 16'h0000, 0, 1, 0, 1, 12'hFFF);
        step(); expect_out("link_wrap", 16'h0, 1, 4'd4, 16'h0000, 0, 12'h0, 0, 16'd5);
        bundle(4'd4, 16'h1111, 16'h2222, 1, 1, 0, 1, 12'h7FF);
        step(); expect_out("link_mid", 16'h3333, 1, 4'd4, 16'h0800, 0, 12'h333, 0, 16'd5);

        // Jump without add targets 0.
        bundle(4'd0, 16'h0005, 16'h0006, 0, 0, 1, 0, 12'h123);
        step(); expect_out("jmp_noadd", 16'h0, 0, 4'd0, 16'h0, 1, 12'h000, 1, 16'd5);
        idle();
        step(); step();

        // Plain add write; index 0 style behaviour is not special, counter steady.
        bundle(4'd7, 16'h1234, 16'h0001, 1, 0, 0, 1, 12'h000);
        step(); expect_out("add_wr", 16'h1235, 1, 4'd7, 16'h1235, 0, 12'h235, 0, 16'd6);
        bundle(4'd0, 16'h00A0, 16'h000B, 1, 0, 0, 1, 12'h000);
        step(); expect_out("add_idx0", 16'h00AB, 1, 4'd0, 16'h00AB, 0, 12'h0AB, 0, 16'd6);

        // Asynchronous reset in the middle of a flush window.
        bundle(4'd2, 16'h0010, 16'h0020, 1, 0, 1, 1, 12'h000);
        step(); expect_out("pre_reset", 16'h0030, 1, 4'd2, 16'h0030, 1, 12'h030, 1, 16'd6);
        idle();
        #2 reset = 1'b1;
        #1;
        expect_out("async_reset", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 0, 16'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        expect_out("post_release", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 0, 16'd0);
        step(); expect_out("post_release_idle", 16'h0, 0, 4'd0, 16'h0, 0, 12'h0, 0, 16'd0);
        bundle(4'd7, 16'h1234, 16'h0001, 1, 0, 0, 1, 12'h000);
        step(); expect_out("recover", 16'h1235, 1, 4'd7, 16'h1235, 0, 12'h235, 0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
